axi_stream_bridge: RTL and testbench

AXI_STREAM_BRIDGE -- requirements
Module: axi_stream_bridge

---
 rtl/axi_bridge_pkg.sv | 33 +++
 rtl/sync_fifo.sv | 60 ++++++
 rtl/axi_stream_bridge.sv | 285 ++++++++++++++++++++++++++++
 tb/tb_axi_stream_bridge.sv | 377 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_bridge_pkg.sv
// Shared register map, response codes and FSM state types for the AXI-to-stream bridge.
package axi_bridge_pkg;

    localparam logic [7:0] OFF_CTRL     = 8'h00;
    localparam logic [7:0] OFF_DATA_IN  = 8'h04;
    localparam logic [7:0] OFF_DATA_OUT = 8'h08;
    localparam logic [7:0] OFF_STATUS   = 8'h0C;
    localparam logic [7:0] OFF_IRQ_CLR  = 8'h10;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        W_IDLE,
        W_DATA,
        W_RESP
    } wstate_e;

    typedef enum logic {
        R_IDLE,
        R_DATA
    } rstate_e;

    function automatic logic wr_ok(input logic [7:0] off);
        return (off == OFF_CTRL) || (off == OFF_DATA_IN) || (off == OFF_IRQ_CLR);
    endfunction

    // Write-only registers read back as unmapped.
    function automatic logic rd_ok(input logic [7:0] off);
        return (off == OFF_CTRL) || (off == OFF_DATA_OUT) || (off == OFF_STATUS);
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO, combinational head, occupancy count.
// A pop frees its slot in the same cycle, so push+pop while full is accepted.
module sync_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 16,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [CW-1:0]    count_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [CW-1:0]    count_q;
    logic             do_push;
    logic             do_pop;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == CW'(DEPTH));
    assign count_o = count_q;
    assign rdata_o = mem_q[rd_ptr_q];
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

endmodule

// File: rtl/axi_stream_bridge.sv
// AXI slave exposing CTRL/STATUS/IRQ registers plus FIFO-backed input and output streams to a core.
// Independent read and write FSMs; bursts never advance the captured register offset.
module axi_stream_bridge
    import axi_bridge_pkg::*;
#(
    parameter int DATA_W    = 32,
    parameter int ID_W      = 8,
    parameter int LEN_W     = 4,
    parameter int IN_DEPTH  = 16,
    parameter int OUT_DEPTH = 16
) (
    input  logic                ACLK,
    input  logic                ARESET,
    input  logic [ID_W-1:0]     AWID,
    input  logic [31:0]         AWADDR,
    input  logic [LEN_W-1:0]    AWLEN,
    input  logic [2:0]          AWSIZE,
    input  logic [1:0]          AWBURST,
    input  logic                AWVALID,
    output logic                AWREADY,
    input  logic [DATA_W-1:0]   WDATA,
    input  logic [DATA_W/8-1:0] WSTRB,
    input  logic                WLAST,
    input  logic                WVALID,
    output logic                WREADY,
    output logic [ID_W-1:0]     BID,
    output logic [1:0]          BRESP,
    output logic                BVALID,
    input  logic                BREADY,
    input  logic [ID_W-1:0]     ARID,
    input  logic [31:0]         ARADDR,
    input  logic [LEN_W-1:0]    ARLEN,
    input  logic [2:0]          ARSIZE,
    input  logic [1:0]          ARBURST,
    input  logic                ARVALID,
    output logic                ARREADY,
    output logic [ID_W-1:0]     RID,
    output logic [DATA_W-1:0]   RDATA,
    output logic [1:0]          RRESP,
    output logic                RLAST,
    output logic                RVALID,
    input  logic                RREADY,
    output logic [DATA_W-1:0]   in_data_o,
    output logic                in_valid_o,
    input  logic                in_ready_i,
    input  logic [DATA_W-1:0]   out_data_i,
    input  logic                out_valid_i,
    output logic                out_ready_o,
    output logic [DATA_W-1:0]   cfg_o,
    input  logic                done_i,
    output logic                irq_o
);

    localparam int STRB_W = DATA_W / 8;
    localparam int IN_CW  = $clog2(IN_DEPTH + 1);
    localparam int OUT_CW = $clog2(OUT_DEPTH + 1);

    wstate_e            wstate_q, wstate_d;
    logic [ID_W-1:0]    awid_q, awid_d;
    logic [7:0]         waddr_q, waddr_d;
    logic [LEN_W-1:0]   awlen_q, awlen_d;
    logic [LEN_W-1:0]   wcnt_q, wcnt_d;
    logic               werr_q, werr_d;

    rstate_e            rstate_q, rstate_d;
    logic [ID_W-1:0]    arid_q, arid_d;
    logic [7:0]         raddr_q, raddr_d;
    logic [LEN_W-1:0]   arlen_q, arlen_d;
    logic [LEN_W-1:0]   rcnt_q, rcnt_d;

    logic [DATA_W-1:0]  ctrl_q, ctrl_d;
    logic               irq_q, irq_d;

    logic               aw_hs, w_hs, ar_hs, r_hs;
    logic               w_last_beat;
    logic               in_push, in_pop, in_full, in_empty;
    logic [DATA_W-1:0]  in_head;
    logic [IN_CW-1:0]   in_count;
    logic               out_push, out_pop, out_full, out_empty;
    logic [DATA_W-1:0]  out_head;
    logic [OUT_CW-1:0]  out_count;
    logic [DATA_W-1:0]  status;
    logic               unused_ok;

    assign unused_ok = ^{AWADDR[31:8], AWSIZE, AWBURST, ARADDR[31:8], ARSIZE, ARBURST};

    // Readies are held low while reset is asserted so no handshake can be seen mid-reset.
    assign AWREADY = (wstate_q == W_IDLE) && !ARESET;
    assign WREADY  = (wstate_q == W_DATA) && ((waddr_q == OFF_DATA_IN) ? !in_full : 1'b1);
    assign BVALID  = (wstate_q == W_RESP);
    assign BID     = awid_q;
    assign BRESP   = (BVALID && (werr_q || !wr_ok(waddr_q))) ? RESP_SLVERR : RESP_OKAY;

    assign aw_hs       = AWVALID && AWREADY;
    assign w_hs        = WVALID && WREADY;
    assign w_last_beat = (wcnt_q == awlen_q);

    always_comb begin
        wstate_d = wstate_q;
        awid_d   = awid_q;
        waddr_d  = waddr_q;
        awlen_d  = awlen_q;
        wcnt_d   = wcnt_q;
        werr_d   = werr_q;
        case (wstate_q)
            W_IDLE: begin
                if (aw_hs) begin
                    awid_d   = AWID;
                    waddr_d  = AWADDR[7:0];
                    awlen_d  = AWLEN;
                    wcnt_d   = '0;
                    werr_d   = 1'b0;
                    wstate_d = W_DATA;
                end
            end
            W_DATA: begin
                if (w_hs) begin
                    if (WLAST != w_last_beat) begin
                        werr_d = 1'b1;
                    end
                    wcnt_d = wcnt_q + LEN_W'(1);
                    if (w_last_beat) begin
                        wstate_d = W_RESP;
                    end
                end
            end
            W_RESP: begin
                if (BREADY) begin
                    wstate_d = W_IDLE;
                end
            end
            default: wstate_d = W_IDLE;
        endcase
    end

    // done_i is applied last so a coincident set beats the clear.
    always_comb begin
        ctrl_d = ctrl_q;
        irq_d  = irq_q;
        if (w_hs && (waddr_q == OFF_CTRL)) begin
            for (int b = 0; b < STRB_W; b++) begin
                if (WSTRB[b]) begin
                    ctrl_d[8*b +: 8] = WDATA[8*b +: 8];
                end
            end
        end
        if (w_hs && (waddr_q == OFF_IRQ_CLR) && WDATA[0]) begin
            irq_d = 1'b0;
        end
        if (done_i) begin
            irq_d = 1'b1;
        end
    end

    assign ARREADY = (rstate_q == R_IDLE) && !ARESET;
    assign RVALID  = (rstate_q == R_DATA) && ((raddr_q == OFF_DATA_OUT) ? !out_empty : 1'b1);
    assign RID     = arid_q;
    assign RLAST   = RVALID && (rcnt_q == arlen_q);
    assign RRESP   = (RVALID && !rd_ok(raddr_q)) ? RESP_SLVERR : RESP_OKAY;

    assign ar_hs = ARVALID && ARREADY;
    assign r_hs  = RVALID && RREADY;

    always_comb begin
        status        = '0;
        status[7:0]   = 8'(in_count);
        status[15:8]  = 8'(out_count);
        status[31]    = irq_q;
    end

    always_comb begin
        RDATA = '0;
        if (RVALID) begin
            case (raddr_q)
                OFF_CTRL:     RDATA = ctrl_q;
                OFF_DATA_OUT: RDATA = out_head;
                OFF_STATUS:   RDATA = status;
                default:      RDATA = '0;
            endcase
        end
    end

    always_comb begin
        rstate_d = rstate_q;
        arid_d   = arid_q;
        raddr_d  = raddr_q;
        arlen_d  = arlen_q;
        rcnt_d   = rcnt_q;
        case (rstate_q)
            R_IDLE: begin
                if (ar_hs) begin
                    arid_d   = ARID;
                    raddr_d  = ARADDR[7:0];
                    arlen_d  = ARLEN;
                    rcnt_d   = '0;
                    rstate_d = R_DATA;
                end
            end
            R_DATA: begin
                if (r_hs) begin
                    rcnt_d = rcnt_q + LEN_W'(1);
                    if (rcnt_q == arlen_q) begin
                        rstate_d = R_IDLE;
                    end
                end
            end
            default: rstate_d = R_IDLE;
        endcase
    end

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            wstate_q <= W_IDLE;
            awid_q   <= '0;
            waddr_q  <= '0;
            awlen_q  <= '0;
            wcnt_q   <= '0;
            werr_q   <= 1'b0;
            rstate_q <= R_IDLE;
            arid_q   <= '0;
            raddr_q  <= '0;
            arlen_q  <= '0;
            rcnt_q   <= '0;
            ctrl_q   <= '0;
            irq_q    <= 1'b0;
        end else begin
            wstate_q <= wstate_d;
            awid_q   <= awid_d;
            waddr_q  <= waddr_d;
            awlen_q  <= awlen_d;
            wcnt_q   <= wcnt_d;
            werr_q   <= werr_d;
            rstate_q <= rstate_d;
            arid_q   <= arid_d;
            raddr_q  <= raddr_d;
            arlen_q  <= arlen_d;
            rcnt_q   <= rcnt_d;
            ctrl_q   <= ctrl_d;
            irq_q    <= irq_d;
        end
    end

    assign in_push    = w_hs && (waddr_q == OFF_DATA_IN);
    assign in_pop     = in_valid_o && in_ready_i;
    assign in_valid_o = !in_empty;
    assign in_data_o  = in_empty ? '0 : in_head;

    assign out_ready_o = !out_full;
    assign out_push    = out_valid_i && out_ready_o;
    assign out_pop     = r_hs && (raddr_q == OFF_DATA_OUT);

    assign cfg_o = ctrl_q;
    assign irq_o = irq_q;

    sync_fifo #(
        .WIDTH (DATA_W),
        .DEPTH (IN_DEPTH)
    ) u_in_fifo (
        .clk_i   (ACLK),
        .rst_i   (ARESET),
        .push_i  (in_push),
        .wdata_i (WDATA),
        .pop_i   (in_pop),
        .rdata_o (in_head),
        .full_o  (in_full),
        .empty_o (in_empty),
        .count_o (in_count)
    );

    sync_fifo #(
        .WIDTH (DATA_W),
        .DEPTH (OUT_DEPTH)
    ) u_out_fifo (
        .clk_i   (ACLK),
        .rst_i   (ARESET),
        .push_i  (out_push),
        .wdata_i (out_data_i),
        .pop_i   (out_pop),
        .rdata_o (out_head),
        .full_o  (out_full),
        .empty_o (out_empty),
        .count_o (out_count)
    );

endmodule

// File: tb/tb_axi_stream_bridge.sv
// Directed bench for axi_stream_bridge: register access, stream FIFOs, IRQ, error responses, reset.
module tb_axi_stream_bridge;

    localparam int LIMIT = 200;

    logic        ACLK = 1'b0;
    logic        ARESET;
    logic [7:0]  AWID;
    logic [31:0] AWADDR;
    logic [3:0]  AWLEN;
    logic [2:0]  AWSIZE;
    logic [1:0]  AWBURST;
    logic        AWVALID;
    logic        AWREADY;
    logic [31:0] WDATA;
    logic [3:0]  WSTRB;
    logic        WLAST;
    logic        WVALID;
    logic        WREADY;
    logic [7:0]  BID;
    logic [1:0]  BRESP;
    logic        BVALID;
    logic        BREADY;
    logic [7:0]  ARID;
    logic [31:0] ARADDR;
    logic [3:0]  ARLEN;
    logic [2:0]  ARSIZE;
    logic [1:0]  ARBURST;
    logic        ARVALID;
    logic        ARREADY;
    logic [7:0]  RID;
    logic [31:0] RDATA;
    logic [1:0]  RRESP;
    logic        RLAST;
    logic        RVALID;
    logic        RREADY;
    logic [31:0] in_data_o;
    logic        in_valid_o;
    logic        in_ready_i;
    logic [31:0] out_data_i;
    logic        out_valid_i;
    logic        out_ready_o;
    logic [31:0] cfg_o;
    logic        done_i;
    logic        irq_o;

    int n_cmp = 0;
    int n_err = 0;
    logic [31:0] exp_q[$];
    logic [31:0] drained_q[$];

    always #5 ACLK = ~ACLK;

    axi_stream_bridge dut (
        .ACLK(ACLK), .ARESET(ARESET),
        .AWID(AWID), .AWADDR(AWADDR), .AWLEN(AWLEN), .AWSIZE(AWSIZE), .AWBURST(AWBURST),
        .AWVALID(AWVALID), .AWREADY(AWREADY),
        .WDATA(WDATA), .WSTRB(WSTRB), .WLAST(WLAST), .WVALID(WVALID), .WREADY(WREADY),
        .BID(BID), .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
        .ARID(ARID), .ARADDR(ARADDR), .ARLEN(ARLEN), .ARSIZE(ARSIZE), .ARBURST(ARBURST),
        .ARVALID(ARVALID), .ARREADY(ARREADY),
        .RID(RID), .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST), .RVALID(RVALID), .RREADY(RREADY),
        .in_data_o(in_data_o), .in_valid_o(in_valid_o), .in_ready_i(in_ready_i),
        .out_data_i(out_data_i), .out_valid_i(out_valid_i), .out_ready_o(out_ready_o),
        .cfg_o(cfg_o), .done_i(done_i), .irq_o(irq_o)
    );

    // Records every word the core accepts; inputs are stable from negedge+1 until the next posedge.
    always begin
        @(negedge ACLK);
        #1;
        if (in_valid_o && in_ready_i) drained_q.push_back(in_data_o);
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic do_aw(input logic [31:0] addr, input logic [3:0] len, input logic [7:0] id);
        int n = 0;
        @(negedge ACLK);
        AWVALID = 1'b1; AWADDR = addr; AWLEN = len; AWID = id;
        #1;
        while (!AWREADY && n < LIMIT) begin @(negedge ACLK); #1; n++; end
        if (n >= LIMIT) chk("aw_timeout", AWREADY, 1);
        @(posedge ACLK);
        #1 AWVALID = 1'b0;
    endtask

    task automatic wbeat(input logic [31:0] d, input logic [3:0] s, input logic l);
        int n = 0;
        @(negedge ACLK);
        WVALID = 1'b1; WDATA = d; WSTRB = s; WLAST = l;
        #1;
        while (!WREADY && n < LIMIT) begin @(negedge ACLK); #1; n++; end
        if (n >= LIMIT) chk("w_timeout", WREADY, 1);
        @(posedge ACLK);
        #1 WVALID = 1'b0;
    endtask

    task automatic get_b(output logic [1:0] resp, output logic [7:0] id);
        int n = 0;
        @(negedge ACLK);
        BREADY = 1'b1;
        #1;
        while (!BVALID && n < LIMIT) begin @(negedge ACLK); #1; n++; end
        if (n >= LIMIT) chk("b_timeout", BVALID, 1);
        resp = BRESP; id = BID;
        @(posedge ACLK);
        #1 BREADY = 1'b0;
    endtask

    task automatic do_ar(input logic [31:0] addr, input logic [3:0] len, input logic [7:0] id);
        int n = 0;
        @(negedge ACLK);
        ARVALID = 1'b1; ARADDR = addr; ARLEN = len; ARID = id;
        #1;
        while (!ARREADY && n < LIMIT) begin @(negedge ACLK); #1; n++; end
        if (n >= LIMIT) chk("ar_timeout", ARREADY, 1);
        @(posedge ACLK);
        #1 ARVALID = 1'b0;
    endtask

    task automatic get_r(output logic [31:0] d, output logic [1:0] resp, output logic last,
                         output logic [7:0] id);
        int n = 0;
        @(negedge ACLK);
        RREADY = 1'b1;
        #1;
        while (!RVALID && n < LIMIT) begin @(negedge ACLK); #1; n++; end
        if (n >= LIMIT) chk("r_timeout", RVALID, 1);
        d = RDATA; resp = RRESP; last = RLAST; id = RID;
        @(posedge ACLK);
        #1 RREADY = 1'b0;
    endtask

    task automatic write1(input string tag, input logic [31:0] addr, input logic [31:0] d,
                          input logic [3:0] s, input logic [1:0] exp_resp);
        logic [1:0] resp;
        logic [7:0] id;
        do_aw(addr, 4'd0, 8'h11);
        wbeat(d, s, 1'b1);
        get_b(resp, id);
        chk(tag, resp, exp_resp);
    endtask

    task automatic read1(input string tag, input logic [31:0] addr, input logic [31:0] exp_d,
                         input logic [1:0] exp_resp);
        logic [31:0] d;
        logic [1:0]  resp;
        logic        last;
        logic [7:0]  id;
        do_ar(addr, 4'd0, 8'h22);
        get_r(d, resp, last, id);
        chk({tag, "_data"}, d, exp_d);
        chk({tag, "_resp"}, resp, exp_resp);
        chk({tag, "_last"}, last, 1);
    endtask

    task automatic core_push(input logic [31:0] d);
        int n = 0;
        @(negedge ACLK);
        out_valid_i = 1'b1; out_data_i = d;
        #1;
        while (!out_ready_o && n < LIMIT) begin @(negedge ACLK); #1; n++; end
        if (n >= LIMIT) chk("core_push_timeout", out_ready_o, 1);
        @(posedge ACLK);
        #1 out_valid_i = 1'b0;
    endtask

    task automatic wait_drain_and_check(input string tag);
        int n = 0;
        #1;
        while (in_valid_o && n < LIMIT) begin @(negedge ACLK); #2; n++; end
        if (n >= LIMIT) chk({tag, "_drain_timeout"}, in_valid_o, 0);
        chk({tag, "_count"}, drained_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < drained_q.size(); i++)
            chk({tag, "_word"}, drained_q[i], exp_q[i]);
        exp_q.delete();
        drained_q.delete();
    endtask

    initial begin
        logic [31:0] d;
        logic [1:0]  resp;
        logic        last;
        logic [7:0]  id;

        ARESET = 1'b1;
        AWID = '0; AWADDR = '0; AWLEN = '0; AWSIZE = 3'b010; AWBURST = 2'b01; AWVALID = 1'b0;
        WDATA = '0; WSTRB = '0; WLAST = 1'b0; WVALID = 1'b0; BREADY = 1'b0;
        ARID = '0; ARADDR = '0; ARLEN = '0; ARSIZE = 3'b010; ARBURST = 2'b01; ARVALID = 1'b0;
        RREADY = 1'b0; in_ready_i = 1'b0; out_data_i = '0; out_valid_i = 1'b0; done_i = 1'b0;

        // Reset state
        repeat (3) @(posedge ACLK);
        #1;
        chk("rst_awready", AWREADY, 0);
        chk("rst_arready", ARREADY, 0);
        chk("rst_bvalid", BVALID, 0);
        chk("rst_rvalid", RVALID, 0);
        chk("rst_in_valid", in_valid_o, 0);
        chk("rst_out_ready", out_ready_o, 1);
        chk("rst_irq", irq_o, 0);
        chk("rst_cfg", cfg_o, 0);
        @(negedge ACLK);
        ARESET = 1'b0;
        #1;
        chk("post_rst_awready", AWREADY, 1);
        chk("post_rst_arready", ARREADY, 1);

        // CTRL write/read, BID echo, byte strobes, 8-bit decode aliasing
        do_aw(32'h0, 4'd0, 8'h5A);
        wbeat(32'h0000_3EE0, 4'hF, 1'b1);
        get_b(resp, id);
        chk("ctrl_bresp", resp, 2'b00);
        chk("ctrl_bid", id, 8'h5A);
        chk("ctrl_cfg", cfg_o, 32'h0000_3EE0);
        read1("ctrl_rd", 32'h0, 32'h0000_3EE0, 2'b00);
        write1("ctrl_strb_bresp", 32'h0, 32'hAABB_CCDD, 4'b0101, 2'b00);
        chk("ctrl_strb_cfg", cfg_o, 32'h00BB_3EDD);
        read1("ctrl_alias_rd", 32'h0000_0100, 32'h00BB_3EDD, 2'b00);

        // 16-beat DATA_IN burst into a stalled core
        do_aw(32'h4, 4'd15, 8'h01);
        wbeat(32'hA000_0000, 4'hF, 1'b0);
        exp_q.push_back(32'hA000_0000);
        chk("in_valid_next_cycle", in_valid_o, 1);
        chk("in_data_next_cycle", in_data_o, 32'hA000_0000);
        for (int i = 1; i < 16; i++) begin
            wbeat(32'hA000_0000 + i, 4'h0, i == 15);
            exp_q.push_back(32'hA000_0000 + i);
        end
        get_b(resp, id);
        chk("burst16_bresp", resp, 2'b00);
        read1("burst16_status", 32'hC, 32'h0000_0010, 2'b00);
        @(negedge ACLK);
        in_ready_i = 1'b1;
        wait_drain_and_check("burst16");
        @(negedge ACLK);
        in_ready_i = 1'b0;

        // Back-pressure: 14 queued, 4-beat burst stalls after 2 beats
        do_aw(32'h4, 4'd13, 8'h02);
        for (int i = 0; i < 14; i++) begin
            wbeat(32'hB000_0000 + i, 4'hF, i == 13);
            exp_q.push_back(32'hB000_0000 + i);
        end
        get_b(resp, id);
        chk("prefill_bresp", resp, 2'b00);
        do_aw(32'h4, 4'd3, 8'h03);
        wbeat(32'hC000_0000, 4'hF, 1'b0);
        wbeat(32'hC000_0001, 4'hF, 1'b0);
        exp_q.push_back(32'hC000_0000);
        exp_q.push_back(32'hC000_0001);
        @(negedge ACLK);
        WVALID = 1'b1; WDATA = 32'hC000_0002; WSTRB = 4'hF; WLAST = 1'b0;
        #1;
        chk("full_wready_low", WREADY, 0);
        repeat (2) @(posedge ACLK);
        #1;
        chk("full_wready_still_low", WREADY, 0);
        read1("full_status_overlap", 32'hC, 32'h0000_0010, 2'b00);
        @(negedge ACLK);
        in_ready_i = 1'b1;
        wbeat(32'hC000_0002, 4'hF, 1'b0);
        wbeat(32'hC000_0003, 4'hF, 1'b1);
        exp_q.push_back(32'hC000_0002);
        exp_q.push_back(32'hC000_0003);
        get_b(resp, id);
        chk("stall_bresp", resp, 2'b00);
        wait_drain_and_check("stall");
        @(negedge ACLK);
        in_ready_i = 1'b0;

        // DATA_OUT read burst of 4 with only 2 words available
        core_push(32'hD000_0000);
        core_push(32'hD000_0001);
        do_ar(32'h8, 4'd3, 8'h33);
        #1;
        chk("rd_busy_arready", ARREADY, 0);
        for (int i = 0; i < 2; i++) begin
            get_r(d, resp, last, id);
            chk("dout_data", d, 32'hD000_0000 + i);
            chk("dout_last_early", last, 0);
        end
        chk("dout_rid", id, 8'h33);
        @(negedge ACLK);
        RREADY = 1'b1;
        #1;
        chk("dout_stall", RVALID, 0);
        repeat (2) @(posedge ACLK);
        #1;
        chk("dout_stall_hold", RVALID, 0);
        @(negedge ACLK);
        RREADY = 1'b0;
        core_push(32'hD000_0002);
        core_push(32'hD000_0003);
        get_r(d, resp, last, id);
        chk("dout_beat3", d, 32'hD000_0002);
        chk("dout_beat3_last", last, 0);
        get_r(d, resp, last, id);
        chk("dout_beat4", d, 32'hD000_0003);
        chk("dout_beat4_last", last, 1);
        chk("dout_resp", resp, 2'b00);
        #1;
        chk("rd_done_arready", ARREADY, 1);

        // IRQ: set wins over a coincident clear
        @(negedge ACLK);
        done_i = 1'b1;
        @(negedge ACLK);
        done_i = 1'b0;
        #1;
        chk("irq_set", irq_o, 1);
        read1("irq_status", 32'hC, 32'h8000_0000, 2'b00);
        do_aw(32'h10, 4'd0, 8'h44);
        @(negedge ACLK);
        WVALID = 1'b1; WDATA = 32'h1; WSTRB = 4'hF; WLAST = 1'b1; done_i = 1'b1;
        #1;
        chk("irqclr_wready", WREADY, 1);
        @(posedge ACLK);
        #1;
        WVALID = 1'b0; done_i = 1'b0;
        #1;
        chk("irq_set_wins", irq_o, 1);
        get_b(resp, id);
        chk("irqclr_bresp", resp, 2'b00);
        write1("irqclr2_bresp", 32'h10, 32'h1, 4'hF, 2'b00);
        chk("irq_cleared", irq_o, 0);

        // Error responses
        write1("unmapped_wr", 32'h20, 32'hDEAD_BEEF, 4'hF, 2'b10);
        write1("ro_status_wr", 32'hC, 32'h1, 4'hF, 2'b10);
        do_aw(32'h0, 4'd3, 8'h55);
        wbeat(32'h1, 4'hF, 1'b0);
        wbeat(32'h2, 4'hF, 1'b1);
        wbeat(32'h3, 4'hF, 1'b0);
        wbeat(32'h1234_5678, 4'hF, 1'b1);
        get_b(resp, id);
        chk("early_wlast_bresp", resp, 2'b10);
        chk("early_wlast_cfg", cfg_o, 32'h1234_5678);
        read1("unmapped_rd", 32'h20, 32'h0, 2'b10);

        // Reset mid-burst drops the transaction
        do_aw(32'h4, 4'd3, 8'h66);
        wbeat(32'hE000_0000, 4'hF, 1'b0);
        @(negedge ACLK);
        ARESET = 1'b1;
        #1;
        chk("midrst_bvalid", BVALID, 0);
        chk("midrst_in_valid", in_valid_o, 0);
        chk("midrst_cfg", cfg_o, 0);
        @(negedge ACLK);
        ARESET = 1'b0;
        #1;
        chk("midrst_awready", AWREADY, 1);
        repeat (3) @(posedge ACLK);
        #1;
        chk("midrst_no_b", BVALID, 0);
        chk("midrst_no_r", RVALID, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
